// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// A one-word holding register lets back-to-back words stream with no idle gap.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic            hold_full_q, hold_full_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            x_q, x_d;
    logic            x_valid_q, x_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_end_q, frame_end_d;

    logic            accept;
    logic            last_bit;
    logic            transfer;
    logic [CntW-1:0] next_cnt;

    // Bit presented next on x for a given word image.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word image after the head bit has been consumed; vacated bits fill with 0.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept   = din_valid && !hold_full_q;
    assign last_bit = (state_q == StShift) && (bit_cnt_q == LastCnt);
    assign transfer = hold_full_q && ((state_q == StIdle) || last_bit);
    assign next_cnt = bit_cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        shreg_d       = shreg_q;
        hold_full_d   = hold_full_q;
        bit_cnt_d     = bit_cnt_q;
        x_d           = x_q;
        x_valid_d     = x_valid_q;
        frame_start_d = frame_start_q;
        frame_end_d   = frame_end_q;

        // accept and transfer are mutually exclusive: accept needs hold empty.
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end

        if (transfer) begin
            shreg_d       = advance(hold_q);
            hold_full_d   = 1'b0;
            state_d       = StShift;
            bit_cnt_d     = '0;
            x_d           = head_bit(hold_q);
            x_valid_d     = 1'b1;
            frame_start_d = 1'b1;
            frame_end_d   = 1'b0;
        end else if (state_q == StShift) begin
            if (!last_bit) begin
                bit_cnt_d     = next_cnt;
                x_d           = head_bit(shreg_q);
                shreg_d       = advance(shreg_q);
                frame_start_d = 1'b0;
                frame_end_d   = (next_cnt == LastCnt);
            end else begin
                state_d       = StIdle;
                x_d           = IDLE_BIT;
                x_valid_d     = 1'b0;
                frame_start_d = 1'b0;
                frame_end_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            shreg_q       <= '0;
            hold_full_q   <= 1'b0;
            bit_cnt_q     <= '0;
            x_q           <= IDLE_BIT;
            x_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            shreg_q       <= shreg_d;
            hold_full_q   <= hold_full_d;
            bit_cnt_q     <= bit_cnt_d;
            x_q           <= x_d;
            x_valid_q     <= x_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign din_ready   = !hold_full_q;
    assign busy        = (state_q == StShift) || hold_full_q;
    assign x           = x_q;
    assign x_valid     = x_valid_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances side by side.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_m, din_l;
    logic       dv_m, dv_l;
    logic       rdy_m, x_m, xv_m, fs_m, fe_m, busy_m;
    logic       rdy_l, x_l, xv_l, fs_l, fe_l, busy_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
        .x(x_m), .x_valid(xv_m), .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
        .x(x_l), .x_valid(xv_l), .frame_start(fs_l), .frame_end(fe_l), .busy(busy_l)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_msb;  // bit 7 is the first serial bit
        logic [7:0] exp_lsb;
        int         exp_det;  // overlapping 1011 hits within the word
    } vec_t;

    vec_t vecs[7];
    logic [7:0] words[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_stream(input int n, input logic [23:0] exp_bits);
        logic [23:0] bits;
        int nvalid, gaps, fs_cnt, fe_cnt, fe_fs, idx;
        bit will_accept, prev_fe, prev_xv, started, saw_low;
        bits = '0; nvalid = 0; gaps = 0; fs_cnt = 0; fe_cnt = 0; fe_fs = 0; idx = 0;
        prev_fe = 0; prev_xv = 0; started = 0; saw_low = 0;
        @(negedge clk);
        din_m = words[0];
        dv_m = 1'b1;
        will_accept = rdy_m;
        for (int c = 0; c < 8 * n + 8; c++) begin
            @(negedge clk);
            if (xv_m) begin
                bits = {bits[22:0], x_m};
                nvalid++;
                if (started && !prev_xv) gaps++;
                started = 1;
            end
            if (fs_m) fs_cnt++;
            if (fe_m) fe_cnt++;
            if (prev_fe && fs_m) fe_fs++;
            prev_fe = fe_m;
            prev_xv = xv_m;
            if (!rdy_m) saw_low = 1;
            if (will_accept) idx++;
            if (idx < n) begin
                din_m = words[idx];
                dv_m  = 1'b1;
            end else begin
                dv_m = 1'b0;
            end
            will_accept = dv_m && rdy_m;
            // Each later word may only be taken once its predecessor has started.
            if (will_accept && idx > 0) check("accept_order", 32'(fs_cnt), 32'(idx));
        end
        check("stream_bits", 32'(bits), 32'(exp_bits));
        check("stream_nvalid", 32'(nvalid), 32'(8 * n));
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_fs_cnt", 32'(fs_cnt), 32'(n));
        check("stream_fe_cnt", 32'(fe_cnt), 32'(n));
        check("stream_fe_then_fs", 32'(fe_fs), 32'(n - 1));
        check("stream_ready_low", 32'(saw_low), 32'd1);
        check("stream_words_taken", 32'(idx), 32'(n));
        check("stream_idle_after", 32'({xv_m, busy_m}), 32'd0);
    endtask

    initial begin
        logic [3:0] det;
        int         dcount;
        logic [7:0] em, el;
        logic [3:0] exp_m, exp_l;

        vecs[0] = '{8'hB4, 8'hB4, 8'h2D, 1};
        vecs[1] = '{8'h0B, 8'h0B, 8'hD0, 1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 0};
        vecs[3] = '{8'h01, 8'h01, 8'h80, 0};
        vecs[4] = '{8'hC6, 8'hC6, 8'h63, 0};
        vecs[5] = '{8'h2D, 8'h2D, 8'hB4, 1};
        vecs[6] = '{8'h5B, 8'h5B, 8'hDA, 2};

        rst = 1'b1; din_m = '0; din_l = '0; dv_m = 1'b0; dv_l = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_msb", 32'({x_m, xv_m, rdy_m, busy_m, fs_m, fe_m}), 32'b001000);
            check("idle_lsb", 32'({x_l, xv_l, rdy_l, busy_l, fs_l, fe_l}), 32'b001000);
        end

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            check("ready_before", 32'({rdy_m, rdy_l}), 32'b11);
            din_m = vecs[v].din; din_l = vecs[v].din;
            dv_m = 1'b1; dv_l = 1'b1;
            @(negedge clk);
            dv_m = 1'b0; dv_l = 1'b0;
            check("held_not_shifting", 32'({xv_m, xv_l, busy_m, busy_l, rdy_m}), 32'b00110);
            det = '0; dcount = 0;
            em = vecs[v].exp_msb; el = vecs[v].exp_lsb;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                exp_m = {em[7-i], 1'b1, (i == 0), (i == 7)};
                exp_l = {el[7-i], 1'b1, (i == 0), (i == 7)};
                check($sformatf("msb_v%0d_b%0d", v, i), 32'({x_m, xv_m, fs_m, fe_m}), 32'(exp_m));
                check($sformatf("lsb_v%0d_b%0d", v, i), 32'({x_l, xv_l, fs_l, fe_l}), 32'(exp_l));
                if (xv_m) begin
                    det = {det[2:0], x_m};
                    if (det == 4'b1011) dcount++;
                end
            end
            @(negedge clk);
            check("after_word_msb", 32'({x_m, xv_m, fs_m, fe_m, busy_m}), 32'd0);
            check("after_word_lsb", 32'({x_l, xv_l, fs_l, fe_l, busy_l}), 32'd0);
            check($sformatf("detect_v%0d", v), 32'(dcount), 32'(vecs[v].exp_det));
        end

        words[0] = 8'hB4; words[1] = 8'h0B; words[2] = 8'hC6;
        run_stream(2, 24'h00B40B);
        repeat (2) @(negedge clk);
        run_stream(3, 24'hB40BC6);

        // Reset while a word is shifting and another is held.
        repeat (2) @(negedge clk);
        din_m = 8'hFF; dv_m = 1'b1;
        @(negedge clk);
        din_m = 8'hAA;
        @(negedge clk);
        check("rmw_bit0", 32'({x_m, xv_m, fs_m}), 32'b111);
        @(negedge clk);
        dv_m = 1'b0;
        check("rmw_hold_full", 32'({rdy_m, busy_m}), 32'b01);
        @(negedge clk);
        check("rmw_bit2", 32'({x_m, xv_m}), 32'b11);
        #1 rst = 1'b1;
        #1 check("rmw_async", 32'({x_m, xv_m, fs_m, fe_m, rdy_m, busy_m}), 32'b000010);
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rmw_no_resume", 32'({x_m, xv_m, busy_m, rdy_m}), 32'b0001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
